// File: rtl/wishbone_arbiter_rr.sv
// Round-robin arbiter: NUM_MASTERS wishbone masters onto one slave port.
// Grant locks for the whole bus cycle; a per-transfer watchdog forces an error on stalled strobes.
module wishbone_arbiter_rr #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_data_out,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic [NUM_MASTERS*DATA_W-1:0]   m_data_in,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_address,
  output logic [DATA_W-1:0]               s_data_out,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic                            s_ack,
  input  logic                            s_err,
  input  logic [DATA_W-1:0]               s_data_in,
  output logic [NUM_MASTERS-1:0]          grant,
  output logic                            busy
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          owner, owner_nxt;
  logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [IW-1:0]          pick;
  logic                   pick_vld;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   timeout_err;

  // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!pick_vld && m_cyc[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign own_cyc = m_cyc[owner];
  assign own_stb = m_stb[owner];

  // An ack in the expiry cycle wins over the watchdog.
  assign timeout_err = (TIMEOUT > 0) && (state == GRANT) && own_stb && !s_ack && (timer == TMAX);

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    timer_nxt  = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          grant_nxt = NUM_MASTERS'(1) << pick;
        end
      end
      GRANT: begin
        if (!own_cyc) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
        end else if (own_stb && !s_ack && !s_err && !timeout_err) begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      timer  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
      timer  <= timer_nxt;
    end
  end

  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_address  = '0;
    s_data_out = '0;
    s_sel      = '0;
    m_ack      = '0;
    m_err      = '0;
    m_data_in  = '0;
    if (state == GRANT) begin
      s_cyc      = own_cyc;
      s_stb      = own_stb & ~timeout_err;
      s_we       = m_we[owner];
      s_address  = m_address[int'(owner)*ADDR_W +: ADDR_W];
      s_data_out = m_data_out[int'(owner)*DATA_W +: DATA_W];
      s_sel      = m_sel[int'(owner)*SEL_W +: SEL_W];
      m_ack[owner] = s_ack;
      m_err[owner] = s_err | timeout_err;
      m_data_in[int'(owner)*DATA_W +: DATA_W] = s_data_in;
    end
  end

  assign busy = (state == GRANT);

endmodule

// File: tb/tb_wishbone_arbiter_rr.sv
// Scenario bench for wishbone_arbiter_rr (3 masters, TIMEOUT=8) with a response scoreboard.
module tb_wishbone_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_data_out;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_ack, m_err;
  logic [N*DW-1:0] m_data_in;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_address;
  logic [DW-1:0]   s_data_out;
  logic [SW-1:0]   s_sel;
  logic            s_ack, s_err;
  logic [DW-1:0]   s_data_in;
  logic [N-1:0]    grant;
  logic            busy;

  wishbone_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_address(m_address),
    .m_data_out(m_data_out), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_data_in(m_data_in),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_address(s_address),
    .s_data_out(s_data_out), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err), .s_data_in(s_data_in),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          err;
    logic [DW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  resp_t        mon_e;
  logic [N-1:0] mon_oh, mon_ack, mon_err;
  logic [N*DW-1:0] mon_d;

  // Every master-side response must match the next predicted one, in the cycle it was predicted.
  always @(negedge clk) begin
    if (exp_q.size() > 0 || m_ack != '0 || m_err != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp m_ack=%b m_err=%b (none expected)", m_ack, m_err);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_oh  = N'(1) << mon_e.idx;
        mon_ack = mon_e.err ? '0 : mon_oh;
        mon_err = mon_e.err ? mon_oh : '0;
        mon_d   = '0;
        mon_d[mon_e.idx*DW +: DW] = mon_e.data;
        if (m_ack !== mon_ack || m_err !== mon_err || m_data_in !== mon_d)
          begin
            errors++;
            $display("FAIL resp_m%0d got ack=%b err=%b data=%h want ack=%b err=%b data=%h",
                     mon_e.idx, m_ack, m_err, m_data_in, mon_ack, mon_err, mon_d);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] dat, input logic we);
    m_address[i*AW +: AW]  = addr;
    m_data_out[i*DW +: DW] = dat;
    m_sel[i*SW +: SW]      = '1;
    m_we[i]                = we;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_address = '0; m_data_out = '0; m_sel = '0;
    s_ack = 1'b0; s_err = 1'b0; s_data_in = '0;
    tick();
    m_cyc = 3'b111; m_stb = 3'b111;
    tick();
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_address !== '0) begin
      errors++; $display("FAIL reset_slave s_cyc=%b s_stb=%b addr=%h want 0", s_cyc, s_stb, s_address);
    end
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_grant grant=%b busy=%b want 000/0", grant, busy);
    end
    checks++;
    if (m_ack !== '0 || m_err !== '0 || m_data_in !== '0) begin
      errors++; $display("FAIL reset_master ack=%b err=%b data=%h want 0", m_ack, m_err, m_data_in);
    end
    m_cyc = '0; m_stb = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    int g;
    for (int i = 0; i < N; i++) set_m(i, 32'h100 + i, 32'h0, 1'b0);
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int k = 0; k < 4; k++) begin
      g  = k % N;
      oh = N'(1) << g;
      tick();
      checks++;
      if (grant !== oh || s_cyc !== 1'b1 || s_address !== 32'h100 + g) begin
        errors++; $display("FAIL rr_grant_%0d grant=%b s_cyc=%b addr=%h want %b/1/%h", k, grant, s_cyc, s_address, oh, 32'h100 + g);
      end
      s_ack = 1'b1; s_data_in = 32'hD000_0000 + k;
      exp_q.push_back('{g, 1'b0, 32'hD000_0000 + k});
      tick();
      s_ack = 1'b0; m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
      tick();
      checks++;
      if (grant !== '0 || s_cyc !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rr_idle_%0d grant=%b s_cyc=%b busy=%b want 000/0/0", k, grant, s_cyc, busy);
      end
      if (k < 3) begin
        m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
      end else begin
        m_cyc = '0; m_stb = '0;
      end
    end
  endtask

  task automatic test_lock();
    set_m(0, 32'h200, 32'h0, 1'b0);
    set_m(2, 32'h300, 32'h0, 1'b0);
    m_cyc[0] = 1'b1;
    tick();
    checks++;
    if (grant !== 3'b001) begin
      errors++; $display("FAIL lock_first grant=%b want 001", grant);
    end
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_stb[0] = 1'b1;
      tick();
      checks++;
      if (grant !== 3'b001 || s_address !== 32'h200 || s_stb !== 1'b1) begin
        errors++; $display("FAIL lock_beat_%0d grant=%b addr=%h stb=%b want 001/200/1", b, grant, s_address, s_stb);
      end
      s_ack = 1'b1; s_data_in = 32'hB0 + b;
      exp_q.push_back('{0, 1'b0, 32'hB0 + b});
      #1;
      checks++;
      if (m_ack[2] !== 1'b0) begin
        errors++; $display("FAIL lock_no_ack2_%0d m_ack=%b want bit2 0", b, m_ack);
      end
      tick();
      s_ack = 1'b0; m_stb[0] = 1'b0;
      #1;
      checks++;
      if (grant !== 3'b001 || s_stb !== 1'b0 || s_cyc !== 1'b1) begin
        errors++; $display("FAIL lock_gap_%0d grant=%b stb=%b cyc=%b want 001/0/1", b, grant, s_stb, s_cyc);
      end
    end
    m_cyc[0] = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b000) begin
      errors++; $display("FAIL lock_release grant=%b want 000", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b100 || s_address !== 32'h300) begin
      errors++; $display("FAIL lock_handover grant=%b addr=%h want 100/300", grant, s_address);
    end
    s_ack = 1'b1; s_data_in = 32'hC2C2_C2C2;
    exp_q.push_back('{2, 1'b0, 32'hC2C2_C2C2});
    tick();
    s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_m(1, 32'h10, 32'hA5A5_A5A5, 1'b1);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++; $display("FAIL single_latency s_cyc=%b want 0 before grant edge", s_cyc);
    end
    tick();
    checks++;
    if (s_cyc !== 1'b1 || s_we !== 1'b1 || s_address !== 32'h10 || s_data_out !== 32'hA5A5_A5A5 || s_sel !== 4'hF) begin
      errors++; $display("FAIL single_fwd cyc=%b we=%b addr=%h dat=%h sel=%h want 1/1/10/a5a5a5a5/f", s_cyc, s_we, s_address, s_data_out, s_sel);
    end
    checks++;
    if (grant !== 3'b010 || busy !== 1'b1) begin
      errors++; $display("FAIL single_grant grant=%b busy=%b want 010/1", grant, busy);
    end
    tick();
    tick();
    s_ack = 1'b1; s_data_in = 32'h1234_5678;
    exp_q.push_back('{1, 1'b0, 32'h1234_5678});
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    checks++;
    if (grant !== 3'b010) begin
      errors++; $display("FAIL single_hold grant=%b want 010", grant);
    end
    tick();
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release grant=%b busy=%b want 000/0", grant, busy);
    end
  endtask

  task automatic test_timeout();
    set_m(1, 32'h400, 32'h0, 1'b0);
    s_data_in = 32'hEEEE_0001;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i % TO == 0) exp_q.push_back('{1, 1'b1, 32'hEEEE_0001});
      #1;
      checks++;
      if (s_stb !== (i % TO != 0) || m_err[1] !== (i % TO == 0) || grant !== 3'b010) begin
        errors++; $display("FAIL timeout_cyc_%0d stb=%b err=%b grant=%b want %b/%b/010", i, s_stb, m_err[1], grant, (i % TO != 0), (i % TO == 0));
      end
      tick();
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_m(1, 32'h600, 32'h0, 1'b0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      errors++; $display("FAIL rstmid_grant grant=%b want 010", grant);
    end
    tick();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    s_ack = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || m_ack !== '0) begin
      errors++; $display("FAIL rstmid_async cyc=%b stb=%b grant=%b busy=%b ack=%b want all 0", s_cyc, s_stb, grant, busy, m_ack);
    end
    s_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (grant !== 3'b010) begin
      errors++; $display("FAIL rstmid_rearb grant=%b want 010", grant);
    end
    m_cyc = '0; m_stb = '0;
    tick();
  endtask

  task automatic test_timeout_ack();
    set_m(2, 32'h500, 32'h0, 1'b0);
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    tick();
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) begin
        s_ack = 1'b1; s_data_in = 32'h0000_0ACC;
        exp_q.push_back('{2, 1'b0, 32'h0000_0ACC});
      end
      #1;
      checks++;
      if (s_stb !== 1'b1 || m_err !== '0 || m_ack[2] !== (i == TO)) begin
        errors++; $display("FAIL tack_cyc_%0d stb=%b err=%b ack=%b want 1/000/%b", i, s_stb, m_err, m_ack[2], (i == TO));
      end
      tick();
    end
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_single();
    test_timeout();
    test_reset_mid();
    test_timeout_ack();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
